// File: rtl/riscv_bif_arb_pkg.sv
// Shared types for the instruction/data bus-interface arbiter:
// FSM state encodings and the round-robin grant encoding.
package riscv_bif_arb_pkg;

    typedef enum logic [1:0] {
        BIF_ARB_IDLE   = 2'd0,
        BIF_ARB_BUSY_I = 2'd1,
        BIF_ARB_BUSY_D = 2'd2
    } bif_arb_state_t;

    // last_gnt remembers which master won most recently
    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } bif_gnt_t;

    localparam int unsigned BIF_GNT_W  = 2;
    localparam int unsigned GNT_IDX_I  = 0;
    localparam int unsigned GNT_IDX_D  = 1;

endpackage

// File: rtl/riscv_bif_arb_rr.sv
// Combinational two-request round-robin picker; on contention the master
// that did not win last time is granted. Grant is one-hot (or zero).
module riscv_rr_arb2
    import riscv_bif_arb_pkg::*;
(
    input  logic                 instr_req,
    input  logic                 data_req,
    input  bif_gnt_t             last_gnt,
    output logic [BIF_GNT_W-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (instr_req && data_req) begin
            if (last_gnt == GNT_INSTR) gnt[GNT_IDX_D] = 1'b1;
            else                       gnt[GNT_IDX_I] = 1'b1;
        end else if (instr_req) begin
            gnt[GNT_IDX_I] = 1'b1;
        end else if (data_req) begin
            gnt[GNT_IDX_D] = 1'b1;
        end
    end

endmodule

// File: rtl/riscv_bif_arb.sv
// Shares one memory bus between the fetch and data bus interfaces.
// Requests are registered onto mem_bif_*; the completion is routed back combinationally.
module riscv_bif_arb
    import riscv_bif_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_bif_addr,
    input  logic        instr_bif_rdy,
    output logic        instr_bif_ack,
    output logic [31:0] instr_bif_rdata,
    input  logic [31:0] data_bif_addr,
    input  logic        data_bif_rnw,
    input  logic        data_bif_rdy,
    output logic        data_bif_ack,
    output logic [31:0] data_bif_rdata,
    input  logic [31:0] data_bif_wdata,
    input  logic [3:0]  data_bif_wmask,
    output logic [31:0] mem_bif_addr,
    output logic        mem_bif_rnw,
    output logic        mem_bif_rdy,
    input  logic        mem_bif_ack,
    input  logic [31:0] mem_bif_rdata,
    output logic [31:0] mem_bif_wdata,
    output logic [3:0]  mem_bif_wmask
);

    bif_arb_state_t       state_q, state_d;
    bif_gnt_t             last_gnt_q;
    logic [BIF_GNT_W-1:0] gnt;

    riscv_rr_arb2 u_rr_arb2 (
        .instr_req (instr_bif_rdy),
        .data_req  (data_bif_rdy),
        .last_gnt  (last_gnt_q),
        .gnt       (gnt)
    );

    assign instr_bif_rdata = mem_bif_rdata;
    assign data_bif_rdata  = mem_bif_rdata;

    always_comb begin
        state_d       = state_q;
        instr_bif_ack = 1'b0;
        data_bif_ack  = 1'b0;
        case (state_q)
            BIF_ARB_IDLE: begin
                if (gnt[GNT_IDX_I])      state_d = BIF_ARB_BUSY_I;
                else if (gnt[GNT_IDX_D]) state_d = BIF_ARB_BUSY_D;
            end
            BIF_ARB_BUSY_I: begin
                if (mem_bif_ack) begin
                    instr_bif_ack = 1'b1;
                    state_d       = BIF_ARB_IDLE;
                end
            end
            BIF_ARB_BUSY_D: begin
                if (mem_bif_ack) begin
                    data_bif_ack = 1'b1;
                    state_d      = BIF_ARB_IDLE;
                end
            end
            default: state_d = BIF_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= BIF_ARB_IDLE;
        else       state_q <= state_d;
    end

    // Payload loads only on the IDLE->BUSY edge and otherwise holds its last value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt_q    <= GNT_INSTR;
            mem_bif_rdy   <= 1'b0;
            mem_bif_addr  <= '0;
            mem_bif_rnw   <= 1'b1;
            mem_bif_wdata <= '0;
            mem_bif_wmask <= '0;
        end else begin
            case (state_q)
                BIF_ARB_IDLE: begin
                    if (gnt[GNT_IDX_I]) begin
                        last_gnt_q    <= GNT_INSTR;
                        mem_bif_rdy   <= 1'b1;
                        mem_bif_addr  <= instr_bif_addr;
                        mem_bif_rnw   <= 1'b1;
                        mem_bif_wdata <= '0;
                        mem_bif_wmask <= '0;
                    end else if (gnt[GNT_IDX_D]) begin
                        last_gnt_q    <= GNT_DATA;
                        mem_bif_rdy   <= 1'b1;
                        mem_bif_addr  <= data_bif_addr;
                        mem_bif_rnw   <= data_bif_rnw;
                        mem_bif_wdata <= data_bif_wdata;
                        mem_bif_wmask <= data_bif_wmask;
                    end
                end
                BIF_ARB_BUSY_I, BIF_ARB_BUSY_D: begin
                    if (mem_bif_ack) mem_bif_rdy <= 1'b0;
                end
                default: mem_bif_rdy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_bif_arb.sv
// Directed bench for riscv_bif_arb: cycle-by-cycle vector table plus a
// hand-written reset-mid-transfer sequence.
module tb_riscv_bif_arb;

    logic        clk;
    logic        rstn;
    logic [31:0] instr_bif_addr;
    logic        instr_bif_rdy;
    logic        instr_bif_ack;
    logic [31:0] instr_bif_rdata;
    logic [31:0] data_bif_addr;
    logic        data_bif_rnw;
    logic        data_bif_rdy;
    logic        data_bif_ack;
    logic [31:0] data_bif_rdata;
    logic [31:0] data_bif_wdata;
    logic [3:0]  data_bif_wmask;
    logic [31:0] mem_bif_addr;
    logic        mem_bif_rnw;
    logic        mem_bif_rdy;
    logic        mem_bif_ack;
    logic [31:0] mem_bif_rdata;
    logic [31:0] mem_bif_wdata;
    logic [3:0]  mem_bif_wmask;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_bif_arb dut (
        .clk             (clk),
        .rstn            (rstn),
        .instr_bif_addr  (instr_bif_addr),
        .instr_bif_rdy   (instr_bif_rdy),
        .instr_bif_ack   (instr_bif_ack),
        .instr_bif_rdata (instr_bif_rdata),
        .data_bif_addr   (data_bif_addr),
        .data_bif_rnw    (data_bif_rnw),
        .data_bif_rdy    (data_bif_rdy),
        .data_bif_ack    (data_bif_ack),
        .data_bif_rdata  (data_bif_rdata),
        .data_bif_wdata  (data_bif_wdata),
        .data_bif_wmask  (data_bif_wmask),
        .mem_bif_addr    (mem_bif_addr),
        .mem_bif_rnw     (mem_bif_rnw),
        .mem_bif_rdy     (mem_bif_rdy),
        .mem_bif_ack     (mem_bif_ack),
        .mem_bif_rdata   (mem_bif_rdata),
        .mem_bif_wdata   (mem_bif_wdata),
        .mem_bif_wmask   (mem_bif_wmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        i_rdy;
        logic [31:0] i_addr;
        logic        d_rdy;
        logic        d_rnw;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wmask;
        logic        m_ack;
        logic [31:0] m_rdata;
        logic        e_iack;
        logic        e_dack;
        logic        e_mrdy;
        logic [31:0] e_addr;
        logic        e_rnw;
        logic [31:0] e_wdata;
        logic [3:0]  e_wmask;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic i_rdy, input logic [31:0] i_addr,
        input logic d_rdy, input logic d_rnw, input logic [31:0] d_addr,
        input logic [31:0] d_wdata, input logic [3:0] d_wmask,
        input logic m_ack, input logic [31:0] m_rdata,
        input logic e_iack, input logic e_dack, input logic e_mrdy,
        input logic [31:0] e_addr, input logic e_rnw,
        input logic [31:0] e_wdata, input logic [3:0] e_wmask);
        vec_t v;
        v.i_rdy = i_rdy;   v.i_addr = i_addr;
        v.d_rdy = d_rdy;   v.d_rnw = d_rnw;     v.d_addr = d_addr;
        v.d_wdata = d_wdata; v.d_wmask = d_wmask;
        v.m_ack = m_ack;   v.m_rdata = m_rdata;
        v.e_iack = e_iack; v.e_dack = e_dack;   v.e_mrdy = e_mrdy;
        v.e_addr = e_addr; v.e_rnw = e_rnw;
        v.e_wdata = e_wdata; v.e_wmask = e_wmask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_bif_rdy  = v.i_rdy;
        instr_bif_addr = v.i_addr;
        data_bif_rdy   = v.d_rdy;
        data_bif_rnw   = v.d_rnw;
        data_bif_addr  = v.d_addr;
        data_bif_wdata = v.d_wdata;
        data_bif_wmask = v.d_wmask;
        mem_bif_ack    = v.m_ack;
        mem_bif_rdata  = v.m_rdata;
    endtask

    task automatic idle_inputs();
        instr_bif_rdy  = 1'b0;
        instr_bif_addr = '0;
        data_bif_rdy   = 1'b0;
        data_bif_rnw   = 1'b1;
        data_bif_addr  = '0;
        data_bif_wdata = '0;
        data_bif_wmask = '0;
        mem_bif_ack    = 1'b0;
        mem_bif_rdata  = '0;
    endtask

    initial begin
        // A: contention from reset, both held -> D,I,D,I
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 0,0,           0,0,0, 32'h0,   1,0,0));
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 1,32'hAAAA0001, 0,1,1, 32'h3000,1,0,0));
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 0,0,           0,0,0, 32'h3000,1,0,0));
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 1,32'h13,      1,0,1, 32'h200, 1,0,0));
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 0,0,           0,0,0, 32'h200, 1,0,0));
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 1,32'hAAAA0002, 0,1,1, 32'h3000,1,0,0));
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 0,0,           0,0,0, 32'h3000,1,0,0));
        vecs.push_back(mk(1,32'h200, 1,1,32'h3000,0,0, 1,32'h13,      1,0,1, 32'h200, 1,0,0));
        // B: single fetch, memory acks two cycles after seeing rdy
        vecs.push_back(mk(1,32'h100, 0,1,0,0,0, 0,0,           0,0,0, 32'h200, 1,0,0));
        vecs.push_back(mk(1,32'h100, 0,1,0,0,0, 0,0,           0,0,1, 32'h100, 1,0,0));
        vecs.push_back(mk(1,32'h100, 0,1,0,0,0, 0,0,           0,0,1, 32'h100, 1,0,0));
        vecs.push_back(mk(1,32'h100, 0,1,0,0,0, 1,32'h00000013, 1,0,1, 32'h100, 1,0,0));
        // C: store, zero-wait memory
        vecs.push_back(mk(0,0, 1,0,32'h2004,32'hDEADBEEF,4'hC, 0,0, 0,0,0, 32'h100, 1,0,0));
        vecs.push_back(mk(0,0, 1,0,32'h2004,32'hDEADBEEF,4'hC, 1,0, 0,1,1, 32'h2004,0,32'hDEADBEEF,4'hC));
        vecs.push_back(mk(0,0, 0,1,0,0,0, 0,0, 0,0,0, 32'h2004,0,32'hDEADBEEF,4'hC));
        // D: spurious acks in IDLE, including one coinciding with a new request
        vecs.push_back(mk(0,0, 0,1,0,0,0, 1,32'hFFFF0000, 0,0,0, 32'h2004,0,32'hDEADBEEF,4'hC));
        vecs.push_back(mk(0,0, 0,1,0,0,0, 0,0,            0,0,0, 32'h2004,0,32'hDEADBEEF,4'hC));
        vecs.push_back(mk(1,32'h400, 0,1,0,0,0, 1,32'hFFFF0001, 0,0,0, 32'h2004,0,32'hDEADBEEF,4'hC));
        vecs.push_back(mk(1,32'h400, 0,1,0,0,0, 0,0,            0,0,1, 32'h400,1,0,0));
        vecs.push_back(mk(1,32'h400, 0,1,0,0,0, 1,32'h12345678, 1,0,1, 32'h400,1,0,0));
        vecs.push_back(mk(0,0, 0,1,0,0,0, 0,0,                  0,0,0, 32'h400,1,0,0));
        // E: data master drops rdy mid-transfer; transfer still completes
        vecs.push_back(mk(0,0, 1,1,32'h5000,0,0, 0,0,       0,0,0, 32'h400, 1,0,0));
        vecs.push_back(mk(0,0, 0,1,32'h5000,0,0, 0,0,       0,0,1, 32'h5000,1,0,0));
        vecs.push_back(mk(0,0, 0,1,32'h5000,0,0, 1,32'h55,  0,1,1, 32'h5000,1,0,0));
        vecs.push_back(mk(0,0, 0,1,0,0,0,        0,0,       0,0,0, 32'h5000,1,0,0));

        rstn = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("reset mem_rdy",   {31'b0, mem_bif_rdy},   32'd0);
        chk("reset mem_addr",  mem_bif_addr,           32'h0);
        chk("reset mem_rnw",   {31'b0, mem_bif_rnw},   32'd1);
        chk("reset mem_wdata", mem_bif_wdata,          32'h0);
        chk("reset mem_wmask", {28'b0, mem_bif_wmask}, 32'h0);
        chk("reset acks",      {30'b0, instr_bif_ack, data_bif_ack}, 32'd0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("row%0d instr_ack", i), {31'b0, instr_bif_ack}, {31'b0, vecs[i].e_iack});
            chk($sformatf("row%0d data_ack", i),  {31'b0, data_bif_ack},  {31'b0, vecs[i].e_dack});
            chk($sformatf("row%0d mem_rdy", i),   {31'b0, mem_bif_rdy},   {31'b0, vecs[i].e_mrdy});
            chk($sformatf("row%0d mem_addr", i),  mem_bif_addr,           vecs[i].e_addr);
            chk($sformatf("row%0d mem_rnw", i),   {31'b0, mem_bif_rnw},   {31'b0, vecs[i].e_rnw});
            chk($sformatf("row%0d mem_wdata", i), mem_bif_wdata,          vecs[i].e_wdata);
            chk($sformatf("row%0d mem_wmask", i), {28'b0, mem_bif_wmask}, {28'b0, vecs[i].e_wmask});
            if (vecs[i].e_iack)
                chk($sformatf("row%0d instr_rdata", i), instr_bif_rdata, vecs[i].m_rdata);
            if (vecs[i].e_dack)
                chk($sformatf("row%0d data_rdata", i),  data_bif_rdata,  vecs[i].m_rdata);
        end

        // Reset asserted while a store is outstanding
        @(posedge clk);
        #1 idle_inputs();
        data_bif_rdy = 1'b1; data_bif_rnw = 1'b0; data_bif_addr = 32'h6000;
        data_bif_wdata = 32'h0BADF00D; data_bif_wmask = 4'h3;
        @(negedge clk);
        chk("rst seq idle mem_rdy", {31'b0, mem_bif_rdy}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst seq busy mem_rdy",  {31'b0, mem_bif_rdy}, 32'd1);
        chk("rst seq busy mem_addr", mem_bif_addr, 32'h6000);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst async mem_rdy",   {31'b0, mem_bif_rdy}, 32'd0);
        chk("rst async mem_addr",  mem_bif_addr,         32'h0);
        chk("rst async mem_rnw",   {31'b0, mem_bif_rnw}, 32'd1);
        chk("rst async mem_wdata", mem_bif_wdata,        32'h0);
        data_bif_rdy = 1'b0;
        @(posedge clk);
        #1 mem_bif_ack = 1'b1;
        @(negedge clk);
        chk("rst held acks", {30'b0, instr_bif_ack, data_bif_ack}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("late ack acks",    {30'b0, instr_bif_ack, data_bif_ack}, 32'd0);
        chk("late ack mem_rdy", {31'b0, mem_bif_rdy}, 32'd0);
        @(posedge clk);
        #1 mem_bif_ack = 1'b0;
        instr_bif_rdy = 1'b1; instr_bif_addr = 32'h800;
        @(negedge clk);
        chk("post-rst fetch idle mem_rdy", {31'b0, mem_bif_rdy}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post-rst fetch mem_rdy",  {31'b0, mem_bif_rdy}, 32'd1);
        chk("post-rst fetch mem_addr", mem_bif_addr,         32'h800);
        chk("post-rst fetch mem_rnw",  {31'b0, mem_bif_rnw}, 32'd1);
        @(posedge clk);
        #1 mem_bif_ack = 1'b1; mem_bif_rdata = 32'hCAFE0013;
        @(negedge clk);
        chk("post-rst fetch instr_ack",   {31'b0, instr_bif_ack}, 32'd1);
        chk("post-rst fetch data_ack",    {31'b0, data_bif_ack},  32'd0);
        chk("post-rst fetch instr_rdata", instr_bif_rdata,        32'hCAFE0013);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        chk("post-rst fetch done mem_rdy", {31'b0, mem_bif_rdy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
